// File: rtl/key_debounce_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : key_debounce_multi                                             |
// | Brief   : N-channel key synchroniser, debouncer and press/release/long   |
// |           press strobe generator with a power-up settle window.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_debounce_multi #(
  parameter int   N_CH       = 4,
  parameter logic IDLE_LVL   = 1'b1,
  parameter int   T_SETTLE   = 4999,
  parameter int   T_DEBOUNCE = 499999,
  parameter int   T_LONG     = 49999999
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic [N_CH-1:0] Pin_In,
  output logic            Ready,
  output logic [N_CH-1:0] Key_State,
  output logic [N_CH-1:0] H2L_Sig,
  output logic [N_CH-1:0] L2H_Sig,
  output logic [N_CH-1:0] Long_Sig
);

  localparam int c_SET_W  = (T_SETTLE   > 0) ? $clog2(T_SETTLE + 1)   : 1;
  localparam int c_DB_W   = (T_DEBOUNCE > 0) ? $clog2(T_DEBOUNCE + 1) : 1;
  localparam int c_LONG_W = (T_LONG     > 0) ? $clog2(T_LONG + 1)     : 1;

  localparam logic [c_SET_W-1:0]  c_SET_MAX  = c_SET_W'(T_SETTLE);
  localparam logic [c_DB_W-1:0]   c_DB_MAX   = c_DB_W'(T_DEBOUNCE);
  localparam logic [c_LONG_W-1:0] c_LONG_MAX = c_LONG_W'(T_LONG);
  localparam logic [N_CH-1:0]     c_IDLE_VEC = {N_CH{IDLE_LVL}};

  logic [N_CH-1:0]    r_sync1;
  logic [N_CH-1:0]    r_sync2;
  logic [c_SET_W-1:0] r_settle_cnt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sync1      <= c_IDLE_VEC;
      r_sync2      <= c_IDLE_VEC;
      r_settle_cnt <= '0;
      Ready        <= 1'b0;
    end else begin
      r_sync1 <= Pin_In;
      r_sync2 <= r_sync1;
      if (!Ready) begin
        if (r_settle_cnt == c_SET_MAX) begin
          Ready <= 1'b1;
        end else begin
          r_settle_cnt <= r_settle_cnt + c_SET_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              r_key;
    logic              r_h2l;
    logic              r_l2h;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              w_mismatch;
    logic              w_accept;

    assign w_mismatch = (r_sync2[i] != r_key);
    assign w_accept   = Ready && w_mismatch && (r_db_cnt == c_DB_MAX);

    // During settle the debounced level silently tracks the pin so no edge is reported on exit.
    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        r_key    <= IDLE_LVL;
        r_db_cnt <= '0;
        r_h2l    <= 1'b0;
        r_l2h    <= 1'b0;
      end else if (!Ready) begin
        r_key    <= r_sync2[i];
        r_db_cnt <= '0;
        r_h2l    <= 1'b0;
        r_l2h    <= 1'b0;
      end else begin
        r_h2l <= w_accept & ~r_sync2[i];
        r_l2h <= w_accept &  r_sync2[i];
        if (!w_mismatch) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_key    <= r_sync2[i];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + c_DB_W'(1);
        end
      end
    end

    assign Key_State[i] = r_key;
    assign H2L_Sig[i]   = r_h2l;
    assign L2H_Sig[i]   = r_l2h;

    if (T_LONG > 0) begin : g_long
      logic [c_LONG_W-1:0] r_long_cnt;
      logic                r_long;

      // An accept on the same edge clears the count, so a release landing on the terminal count wins.
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          r_long_cnt <= '0;
          r_long     <= 1'b0;
        end else if (!Ready || w_accept || (r_key == IDLE_LVL)) begin
          r_long_cnt <= '0;
          r_long     <= 1'b0;
        end else if (r_long_cnt != c_LONG_MAX) begin
          r_long_cnt <= r_long_cnt + c_LONG_W'(1);
          r_long     <= ((r_long_cnt + c_LONG_W'(1)) == c_LONG_MAX);
        end else begin
          r_long     <= 1'b0;
        end
      end

      assign Long_Sig[i] = r_long;
    end else begin : g_no_long
      assign Long_Sig[i] = 1'b0;
    end
  end

endmodule
`default_nettype wire
